// File: rtl/conv_pkg.sv
// Shared definitions for the convolution sequence controller: the controller
// state encoding and the ReLU clipping used on each finished result.
package conv_pkg;

    // Controller states. LOAD is the idle/fill state and the reset target.
    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_COMPUTE = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_OUT     = 3'd3,
        ST_CLEAR   = 3'd4
    } state_t;

    // ReLU on a sign-extended value; callers cast back to their own width.
    // Works for any result width up to 64 bits.
    function automatic logic signed [63:0] relu(input logic signed [63:0] value);
        return (value < 0) ? 64'sd0 : value;
    endfunction

endpackage

// File: rtl/conv_seq_ctrl.sv
// Sequencer for a 1-D valid convolution y[p] = ReLU(sum_k f[k] * x[p+k]).
// It fills an external x memory from a valid/ready stream, walks the taps of
// every output point through an external MAC, waits for the MAC pipeline to
// settle, and offers each clipped result on a valid/ready output port.
// The memories, the filter ROM and the MAC live outside this module.
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int SIZE_X  = 32,
    parameter int SIZE_F  = 6,
    parameter int T       = 16,
    parameter int MEM_LAT = 1,
    parameter int MAC_LAT = 3,
    localparam int XW = (SIZE_X > 1) ? $clog2(SIZE_X) : 1,
    localparam int FW = (SIZE_F > 1) ? $clog2(SIZE_F) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                x_valid,
    output logic                x_ready,
    output logic [XW-1:0]       x_addr,
    output logic                x_wr_en,
    output logic [FW-1:0]       f_addr,
    output logic                mac_clear,
    output logic                mac_valid_in,
    input  logic signed [T-1:0] mac_f,
    output logic signed [T-1:0] y_data,
    output logic                y_valid,
    input  logic                y_ready,
    output logic                busy
);

    // The drain must cover the memory read latency plus the MAC pipeline;
    // a combined latency of at least one cycle is assumed.
    localparam int DRAIN_LEN = MEM_LAT + MAC_LAT;
    localparam int DW        = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

    localparam logic [XW-1:0] LAST_WORD  = XW'(SIZE_X - 1);
    localparam logic [XW-1:0] LAST_POINT = XW'(SIZE_X - SIZE_F);
    localparam logic [FW-1:0] LAST_TAP   = FW'(SIZE_F - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(DRAIN_LEN - 1);

    state_t                r_state;
    logic [XW-1:0]         r_loadCnt;
    logic [XW-1:0]         r_point;
    logic [FW-1:0]         r_tap;
    logic [DW-1:0]         r_drainCnt;
    logic signed [T-1:0]   r_yData;
    logic                  w_issue;
    logic                  w_lastDrain;

    assign w_issue     = (r_state == ST_COMPUTE);
    assign w_lastDrain = (r_state == ST_DRAIN) && (r_drainCnt == LAST_DRAIN);

    // State machine and the load / point / tap / drain counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_LOAD;
            r_loadCnt  <= '0;
            r_point    <= '0;
            r_tap      <= '0;
            r_drainCnt <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (x_valid) begin
                        if (r_loadCnt == LAST_WORD) begin
                            r_loadCnt <= '0;
                            r_point   <= '0;
                            r_tap     <= '0;
                            r_state   <= ST_COMPUTE;
                        end else begin
                            r_loadCnt <= r_loadCnt + XW'(1);
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (r_tap == LAST_TAP) begin
                        r_tap      <= '0;
                        r_drainCnt <= '0;
                        r_state    <= ST_DRAIN;
                    end else begin
                        r_tap <= r_tap + FW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (r_drainCnt == LAST_DRAIN) begin
                        r_drainCnt <= '0;
                        r_state    <= ST_OUT;
                    end else begin
                        r_drainCnt <= r_drainCnt + DW'(1);
                    end
                end
                ST_OUT: begin
                    if (y_ready) begin
                        r_state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (r_point == LAST_POINT) begin
                        r_point   <= '0;
                        r_loadCnt <= '0;
                        r_state   <= ST_LOAD;
                    end else begin
                        r_point <= r_point + XW'(1);
                        r_tap   <= '0;
                        r_state <= ST_COMPUTE;
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    // Capture the clipped accumulator once the last product has landed;
    // the value then stays put for the whole output handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_yData <= '0;
        end else if (w_lastDrain) begin
            r_yData <= T'(relu(64'(mac_f)));
        end
    end

    // Delay the tap-issue strobe so the MAC sees it together with read data.
    generate
        if (MEM_LAT == 0) begin : g_noDelay
            assign mac_valid_in = w_issue;
        end else begin : g_delay
            logic [MEM_LAT-1:0] r_issueDly;

            // Shift register of issue strobes, one stage per memory cycle.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_issueDly <= '0;
                end else begin
                    r_issueDly <= (r_issueDly << 1) | MEM_LAT'(w_issue);
                end
            end

            assign mac_valid_in = r_issueDly[MEM_LAT-1];
        end
    endgenerate

    // Write strobe is also gated by reset so nothing is written while the
    // block is held in reset, even though the state already reads LOAD.
    assign x_ready   = (r_state == ST_LOAD);
    assign x_wr_en   = (r_state == ST_LOAD) && x_valid && reset;
    assign x_addr    = (r_state == ST_LOAD)    ? r_loadCnt :
                       (r_state == ST_COMPUTE) ? (r_point + XW'(r_tap)) : '0;
    assign f_addr    = (r_state == ST_COMPUTE) ? r_tap : '0;
    assign mac_clear = (r_state == ST_LOAD) || (r_state == ST_CLEAR);
    assign y_valid   = (r_state == ST_OUT);
    assign y_data    = r_yData;
    assign busy      = (r_state != ST_LOAD);

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Testbench for conv_seq_ctrl: models the external x memory, filter ROM and a
// pipelined MAC, and scores every emitted result against a convolution model.
module tb_conv_seq_ctrl;

    localparam int SIZE_X = 32;
    localparam int SIZE_F = 6;
    localparam int T      = 16;
    localparam int NRES   = SIZE_X - SIZE_F + 1;

    logic                clk = 1'b0;
    logic                reset;
    logic                x_valid;
    logic                x_ready;
    logic [4:0]          x_addr;
    logic                x_wr_en;
    logic [2:0]          f_addr;
    logic                mac_clear;
    logic                mac_valid_in;
    logic signed [T-1:0] mac_f;
    logic signed [T-1:0] y_data;
    logic                y_valid;
    logic                y_ready;
    logic                busy;

    int errCount   = 0;
    int checkCount = 0;
    int cyc        = 0;
    int lastAccept = 0;

    int taps[SIZE_F] = '{-186, 77, -141, -84, 68, 141};
    logic signed [T-1:0] xVec [SIZE_X];
    logic signed [T-1:0] xData;

    int expQ[$];
    int hsCycles[$];
    int writeAddrQ[$];
    int writeCycQ[$];

    always #5 clk = ~clk;

    conv_seq_ctrl #(
        .SIZE_X(SIZE_X), .SIZE_F(SIZE_F), .T(T), .MEM_LAT(1), .MAC_LAT(3)
    ) dut (
        .clk(clk), .reset(reset), .x_valid(x_valid), .x_ready(x_ready),
        .x_addr(x_addr), .x_wr_en(x_wr_en), .f_addr(f_addr),
        .mac_clear(mac_clear), .mac_valid_in(mac_valid_in), .mac_f(mac_f),
        .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready), .busy(busy)
    );

    // Cycle counter used for latency and spacing measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // External x memory and filter ROM with one cycle of read latency.
    logic signed [T-1:0] xMem [SIZE_X];
    logic signed [T-1:0] fRom [8];
    logic signed [T-1:0] xRd = '0;
    logic signed [T-1:0] fRd = '0;

    always @(posedge clk) begin
        if (x_wr_en === 1'b1) begin
            xMem[x_addr] <= xData;
            writeAddrQ.push_back(int'(x_addr));
            writeCycQ.push_back(cyc);
        end
        xRd <= xMem[x_addr];
        fRd <= fRom[f_addr];
    end

    // MAC: the accumulator reflects an operand three cycles after its strobe.
    logic                s1v = 1'b0;
    logic                s2v = 1'b0;
    int                  s1p = 0;
    int                  s2p = 0;
    logic signed [T-1:0] acc = '0;

    always @(posedge clk) begin
        s1v <= mac_valid_in;
        s1p <= int'(xRd) * int'(fRd);
        s2v <= s1v;
        s2p <= s1p;
        if (mac_clear === 1'b1) acc <= '0;
        else if (s2v === 1'b1) acc <= acc + T'(s2p);
    end

    assign mac_f = acc;

    // Scoreboard: each accepted output is popped against the model queue.
    always @(negedge clk) begin
        int expV;
        if (y_valid === 1'b1 && y_ready === 1'b1) begin
            hsCycles.push_back(cyc);
            checkCount++;
            if (expQ.size() == 0) begin
                errCount++;
                $display("[TB] FAIL unexpected_result got=%0d expected=none", y_data);
            end else begin
                expV = expQ.pop_front();
                if (int'(y_data) !== expV) begin
                    errCount++;
                    $display("[TB] FAIL result_value got=%0d expected=%0d", y_data, expV);
                end
            end
        end
    end

    // Watchdog so a stuck design still ends the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog_timeout got=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fillRamp();
        for (int i = 0; i < SIZE_X; i++) xVec[i] = T'(i);
    endtask

    // Pushes the model results for xVec, then streams xVec into the DUT.
    task automatic loadVector(input int gap, input int waitBound, input bit keepValid);
        int sum;
        int n;
        for (int p = 0; p < NRES; p++) begin
            sum = 0;
            for (int k = 0; k < SIZE_F; k++) sum += taps[k] * int'(xVec[p + k]);
            expQ.push_back((sum < 0) ? 0 : sum);
        end
        for (int i = 0; i < SIZE_X; i++) begin
            if (gap > 0) begin
                x_valid = 1'b0;
                idle(gap);
            end
            x_valid = 1'b1;
            xData   = xVec[i];
            n = 0;
            while (x_ready !== 1'b1 && n < waitBound) begin
                idle(1);
                n++;
            end
            if (x_ready !== 1'b1) begin
                checkCount++;
                errCount++;
                $display("[TB] FAIL load_timeout word=%0d got=x_ready_%0b expected=1", i, x_ready);
                x_valid = 1'b0;
                return;
            end
            idle(1);
        end
        lastAccept = cyc;
        if (!keepValid) x_valid = 1'b0;
    endtask

    task automatic waitDrain(input int bound);
        int n = 0;
        while (expQ.size() > 0 && n < bound) begin
            idle(1);
            n++;
        end
        if (expQ.size() > 0) begin
            checkCount++;
            errCount++;
            $display("[TB] FAIL results_timeout got=%0d_pending expected=0_pending", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        x_valid = 1'b1;
        idle(2);
        checkCount++; if (x_ready !== 1'b1) begin errCount++; $display("[TB] FAIL rst_x_ready got=%0b expected=1", x_ready); end
        checkCount++; if (mac_clear !== 1'b1) begin errCount++; $display("[TB] FAIL rst_mac_clear got=%0b expected=1", mac_clear); end
        checkCount++; if (x_wr_en !== 1'b0) begin errCount++; $display("[TB] FAIL rst_x_wr_en got=%0b expected=0", x_wr_en); end
        checkCount++; if (mac_valid_in !== 1'b0) begin errCount++; $display("[TB] FAIL rst_mac_valid got=%0b expected=0", mac_valid_in); end
        checkCount++; if (y_valid !== 1'b0) begin errCount++; $display("[TB] FAIL rst_y_valid got=%0b expected=0", y_valid); end
        checkCount++; if (y_data !== 16'sd0) begin errCount++; $display("[TB] FAIL rst_y_data got=%0d expected=0", y_data); end
        checkCount++; if (x_addr !== 5'd0) begin errCount++; $display("[TB] FAIL rst_x_addr got=%0d expected=0", x_addr); end
        checkCount++; if (f_addr !== 3'd0) begin errCount++; $display("[TB] FAIL rst_f_addr got=%0d expected=0", f_addr); end
        checkCount++; if (busy !== 1'b0) begin errCount++; $display("[TB] FAIL rst_busy got=%0b expected=0", busy); end
        x_valid = 1'b0;
        reset   = 1'b1;
        idle(2);
        checkCount++; if (x_ready !== 1'b1 || busy !== 1'b0) begin errCount++; $display("[TB] FAIL post_rst_idle got=ready%0b_busy%0b expected=ready1_busy0", x_ready, busy); end
    endtask

    task automatic test_ramp();
        fillRamp();
        hsCycles.delete();
        loadVector(0, 50, 1'b0);
        waitDrain(400);
        checkCount++;
        if (hsCycles.size() !== NRES) begin errCount++; $display("[TB] FAIL ramp_count got=%0d expected=%0d", hsCycles.size(), NRES); end
        if (hsCycles.size() > 0) begin
            checkCount++;
            if (hsCycles[0] - lastAccept !== 10) begin errCount++; $display("[TB] FAIL first_latency got=%0d expected=10", hsCycles[0] - lastAccept); end
        end
        for (int i = 1; i < hsCycles.size(); i++) begin
            checkCount++;
            if (hsCycles[i] - hsCycles[i-1] !== 12) begin errCount++; $display("[TB] FAIL point_spacing idx=%0d got=%0d expected=12", i, hsCycles[i] - hsCycles[i-1]); end
        end
        idle(2);
        checkCount++; if (busy !== 1'b0 || x_ready !== 1'b1) begin errCount++; $display("[TB] FAIL ramp_back_to_load got=busy%0b_ready%0b expected=busy0_ready1", busy, x_ready); end
    endtask

    task automatic test_ones();
        for (int i = 0; i < SIZE_X; i++) xVec[i] = 16'sd1;
        loadVector(0, 50, 1'b0);
        waitDrain(400);
    endtask

    task automatic test_backpressure();
        int n = 0;
        fillRamp();
        y_ready = 1'b0;
        loadVector(0, 50, 1'b0);
        while (y_valid !== 1'b1 && n < 50) begin idle(1); n++; end
        checkCount++;
        if (y_valid !== 1'b1) begin errCount++; $display("[TB] FAIL bp_wait_valid got=%0b expected=1", y_valid); end
        for (int c = 0; c < 20; c++) begin
            checkCount++; if (y_valid !== 1'b1) begin errCount++; $display("[TB] FAIL bp_valid cyc=%0d got=%0b expected=1", c, y_valid); end
            checkCount++; if (y_data !== 16'sd520) begin errCount++; $display("[TB] FAIL bp_data cyc=%0d got=%0d expected=520", c, y_data); end
            checkCount++; if (mac_clear !== 1'b0) begin errCount++; $display("[TB] FAIL bp_mac_clear cyc=%0d got=%0b expected=0", c, mac_clear); end
            checkCount++; if (x_ready !== 1'b0) begin errCount++; $display("[TB] FAIL bp_x_ready cyc=%0d got=%0b expected=0", c, x_ready); end
            idle(1);
        end
        y_ready = 1'b1;
        waitDrain(400);
    endtask

    task automatic test_load_gaps();
        for (int i = 0; i < SIZE_X; i++) xVec[i] = T'(int'($urandom_range(0, 40)) - 20);
        writeAddrQ.delete();
        loadVector(2, 50, 1'b0);
        checkCount++;
        if (writeAddrQ.size() !== SIZE_X) begin errCount++; $display("[TB] FAIL gap_write_count got=%0d expected=%0d", writeAddrQ.size(), SIZE_X); end
        for (int i = 0; i < writeAddrQ.size(); i++) begin
            checkCount++;
            if (writeAddrQ[i] !== i) begin errCount++; $display("[TB] FAIL gap_write_addr idx=%0d got=%0d expected=%0d", i, writeAddrQ[i], i); end
        end
        checkCount++; if (busy !== 1'b1) begin errCount++; $display("[TB] FAIL gap_busy got=%0b expected=1", busy); end
        waitDrain(400);
    endtask

    task automatic test_reset_midrun();
        int hsBefore;
        fillRamp();
        loadVector(0, 50, 1'b0);
        idle(12 * 3 + 7);
        checkCount++;
        if (busy !== 1'b1 || mac_clear !== 1'b0 || y_valid !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL mid_in_drain got=busy%0b_clr%0b_yv%0b expected=busy1_clr0_yv0", busy, mac_clear, y_valid);
        end
        #2;
        reset = 1'b0;
        #1;
        checkCount++; if (busy !== 1'b0) begin errCount++; $display("[TB] FAIL mid_rst_busy got=%0b expected=0", busy); end
        checkCount++; if (x_ready !== 1'b1) begin errCount++; $display("[TB] FAIL mid_rst_x_ready got=%0b expected=1", x_ready); end
        checkCount++; if (mac_clear !== 1'b1) begin errCount++; $display("[TB] FAIL mid_rst_mac_clear got=%0b expected=1", mac_clear); end
        checkCount++; if (mac_valid_in !== 1'b0) begin errCount++; $display("[TB] FAIL mid_rst_mac_valid got=%0b expected=0", mac_valid_in); end
        checkCount++; if (y_valid !== 1'b0) begin errCount++; $display("[TB] FAIL mid_rst_y_valid got=%0b expected=0", y_valid); end
        checkCount++; if (y_data !== 16'sd0) begin errCount++; $display("[TB] FAIL mid_rst_y_data got=%0d expected=0", y_data); end
        checkCount++; if (x_addr !== 5'd0 || f_addr !== 3'd0) begin errCount++; $display("[TB] FAIL mid_rst_addr got=x%0d_f%0d expected=x0_f0", x_addr, f_addr); end
        checkCount++; if (expQ.size() !== NRES - 3) begin errCount++; $display("[TB] FAIL mid_results_before got=%0d expected=%0d", NRES - expQ.size(), 3); end
        expQ.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        hsBefore = hsCycles.size();
        idle(15);
        checkCount++;
        if (hsCycles.size() !== hsBefore) begin errCount++; $display("[TB] FAIL mid_partial_result got=%0d expected=0", hsCycles.size() - hsBefore); end
        loadVector(0, 50, 1'b0);
        waitDrain(400);
    endtask

    task automatic test_back_to_back();
        fillRamp();
        hsCycles.delete();
        loadVector(0, 50, 1'b1);
        writeAddrQ.delete();
        writeCycQ.delete();
        loadVector(0, 400, 1'b0);
        checkCount++;
        if (hsCycles.size() !== NRES) begin errCount++; $display("[TB] FAIL b2b_first_count got=%0d expected=%0d", hsCycles.size(), NRES); end
        checkCount++;
        if (writeCycQ.size() !== SIZE_X) begin errCount++; $display("[TB] FAIL b2b_write_count got=%0d expected=%0d", writeCycQ.size(), SIZE_X); end
        if (writeCycQ.size() > 0 && hsCycles.size() >= NRES) begin
            checkCount++;
            if (writeCycQ[0] !== hsCycles[NRES-1] + 2) begin errCount++; $display("[TB] FAIL b2b_first_write got=%0d expected=%0d", writeCycQ[0], hsCycles[NRES-1] + 2); end
        end
        for (int i = 0; i < writeAddrQ.size(); i++) begin
            checkCount++;
            if (writeAddrQ[i] !== i) begin errCount++; $display("[TB] FAIL b2b_write_addr idx=%0d got=%0d expected=%0d", i, writeAddrQ[i], i); end
        end
        waitDrain(400);
        checkCount++;
        if (hsCycles.size() !== 2 * NRES) begin errCount++; $display("[TB] FAIL b2b_total got=%0d expected=%0d", hsCycles.size(), 2 * NRES); end
        if (hsCycles.size() > NRES) begin
            checkCount++;
            if (hsCycles[NRES] - lastAccept !== 10) begin errCount++; $display("[TB] FAIL b2b_latency got=%0d expected=10", hsCycles[NRES] - lastAccept); end
        end
    endtask

    // Main sequence.
    initial begin
        reset   = 1'b0;
        x_valid = 1'b0;
        y_ready = 1'b1;
        xData   = '0;
        for (int i = 0; i < SIZE_X; i++) xMem[i] = '0;
        for (int i = 0; i < 8; i++) fRom[i] = (i < SIZE_F) ? T'(taps[i]) : '0;
        $display("[TB] starting conv_seq_ctrl bench");
        test_reset();
        test_ramp();
        test_ones();
        test_backpressure();
        test_load_gaps();
        test_reset_midrun();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
